// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/result bundle between the execute stage and the HI/LO multiply-divide unit
interface muldiv_unit_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, rs, rt, input busy, done, div_by_zero, hi, lo);
    modport slave  (input start, op, rs, rt, output busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle shift-add multiply / restoring divide that owns the HI/LO registers
module muldiv_unit #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input logic           CLK,
    input logic           RST,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a, b, d;
    logic               is_div, neg_q, neg_r;
    logic               accept, sgn, neg_rs, neg_rt, fast, iter, div_ge;
    logic [WIDTH-1:0]   mag_rs, mag_rt, q_fix, r_fix;
    logic [WIDTH:0]     mul_sum, div_shift;
    logic [2*WIDTH-1:0] ext_rs, ext_rt, fast_prod, prod_fix;
    assign accept    = state == IDLE && bus.start;
    assign sgn       = !bus.op[0];
    assign neg_rs    = sgn && bus.rs[WIDTH-1];
    assign neg_rt    = sgn && bus.rt[WIDTH-1];
    assign mag_rs    = neg_rs ? -bus.rs : bus.rs;
    assign mag_rt    = neg_rt ? -bus.rt : bus.rt;
    assign fast      = FAST_MUL && bus.op[2:1] == 2'b00;
    assign iter      = accept && !bus.op[2] && !fast;
    assign ext_rs    = sgn ? {{WIDTH{bus.rs[WIDTH-1]}}, bus.rs} : {{WIDTH{1'b0}}, bus.rs};
    assign ext_rt    = sgn ? {{WIDTH{bus.rt[WIDTH-1]}}, bus.rt} : {{WIDTH{1'b0}}, bus.rt};
    assign fast_prod = ext_rs * ext_rt;
    // a:b is the running product (mul) or remainder:dividend/quotient (div); d is the fixed operand
    assign mul_sum   = {1'b0, a} + (b[0] ? {1'b0, d} : '0);
    assign div_shift = {a, b[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, d};
    assign prod_fix  = neg_q ? -{a, b} : {a, b};
    assign q_fix     = neg_q ? -b : b;
    assign r_fix     = neg_r ? -a : a;
    // state register
    always_ff @(posedge CLK or negedge RST)
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    // next state: RUN lasts WIDTH edges, FIX always one
    always_comb begin
        state_nxt = state == IDLE ? (iter ? RUN : IDLE) :
                    state == RUN  ? (cnt == CW'(1) ? FIX : RUN) : IDLE;
    end
    // busy covers RUN and FIX so new requests wait for the write-back
    always_comb begin
        bus.busy = state != IDLE;
    end
    // datapath, HI/LO and status; divide-by-zero falls out of the normal iteration
    // (quotient all ones, remainder |rs|, which sign correction restores to rs)
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            cnt             <= '0;
            a               <= '0;
            b               <= '0;
            d               <= '0;
            is_div          <= 1'b0;
            neg_q           <= 1'b0;
            neg_r           <= 1'b0;
            bus.hi          <= '0;
            bus.lo          <= '0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                if (bus.op == 3'd4) bus.hi <= bus.rs;
                if (bus.op == 3'd5) bus.lo <= bus.rs;
                if (!bus.op[2]) bus.div_by_zero <= 1'b0;
                if (fast) begin
                    {bus.hi, bus.lo} <= fast_prod;
                    bus.done         <= 1'b1;
                end else if (!bus.op[2]) begin
                    cnt    <= CW'(WIDTH);
                    is_div <= bus.op[1];
                    a      <= '0;
                    b      <= bus.op[1] ? mag_rs : mag_rt;
                    d      <= bus.op[1] ? mag_rt : mag_rs;
                    neg_q  <= neg_rs ^ neg_rt;
                    neg_r  <= neg_rs;
                end
            end
            if (state == RUN) begin
                cnt <= cnt - CW'(1);
                if (is_div) begin
                    a <= div_ge ? div_shift[WIDTH-1:0] - d : div_shift[WIDTH-1:0];
                    b <= {b[WIDTH-2:0], div_ge};
                end else begin
                    {a, b} <= {mul_sum, b[WIDTH-1:1]};
                end
            end
            if (state == FIX) begin
                bus.done <= 1'b1;
                if (is_div) begin
                    bus.hi          <= r_fix;
                    bus.lo          <= d == '0 ? '1 : q_fix;
                    bus.div_by_zero <= d == '0;
                end else begin
                    {bus.hi, bus.lo} <= prod_fix;
                end
            end
        end
endmodule
